// File: rtl/pwm_edge_meter.sv
// Hysteresis slicer feeding a rise-to-rise period / high-time meter.
// Results are handed off through a valid/ready port with a sticky drop flag.
//
// state | meaning
// INIT  | post-reset, counters cleared, heads to SYNC next cycle
// SYNC  | waiting for the first rise; partial period is discarded
// HIGH  | sliced level is 1, counting toward the fall
// LOW   | sliced level is 0, counting toward the closing rise
module pwm_edge_meter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 24,
  parameter int TH_HI = 1000,
  parameter int TH_LO = -1000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic signed [WIDTH-1:0] v_in_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [CNT_W-1:0]        period_o,
  output logic [CNT_W-1:0]        high_cnt_o,
  output logic                    sat_o,
  output logic                    dropped_o,
  output logic                    level_o
);

  localparam logic signed [WIDTH-1:0] TH_HI_W = TH_HI[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] TH_LO_W = TH_LO[WIDTH-1:0];
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic [CNT_W-1:0]        CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SYNC,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t            state_q, state_d;
  logic              level_q, level_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  hcap_q, hcap_d;
  logic              hsat_q, hsat_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              sat_q, sat_d;
  logic              dropped_q, dropped_d;

  logic              rise, fall, publish, load, cnt_at_max;
  logic [CNT_W-1:0]  cnt_inc;

  always_comb begin
    level_d = level_q;
    if (v_in_i >= TH_HI_W) begin
      level_d = 1'b1;
    end else if (v_in_i <= TH_LO_W) begin
      level_d = 1'b0;
    end
  end

  assign rise       = level_d & ~level_q;
  assign fall       = ~level_d & level_q;
  assign cnt_at_max = (cnt_q == CNT_MAX);
  assign cnt_inc    = cnt_at_max ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcap_d  = hcap_q;
    hsat_d  = hsat_q;
    publish = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
        hcap_d  = '0;
        hsat_d  = 1'b0;
      end
      ST_SYNC: begin
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      ST_HIGH: begin
        cnt_d = cnt_inc;
        if (fall) begin
          hcap_d  = cnt_q;
          hsat_d  = cnt_at_max;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (rise) begin
          publish = 1'b1;
          cnt_d   = CNT_ONE;
          hsat_d  = 1'b0;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // A publish into a held, unaccepted result is discarded rather than overwriting it.
  assign load = publish & (~valid_q | out_ready_i);

  always_comb begin
    valid_d   = valid_q;
    period_d  = period_q;
    high_d    = high_q;
    sat_d     = sat_q;
    dropped_d = dropped_q | (publish & valid_q & ~out_ready_i);
    if (load) begin
      valid_d  = 1'b1;
      period_d = cnt_q;
      high_d   = hcap_q;
      sat_d    = cnt_at_max | hsat_q;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_INIT;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      hcap_q    <= '0;
      hsat_q    <= 1'b0;
      valid_q   <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      sat_q     <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      hcap_q    <= hcap_d;
      hsat_q    <= hsat_d;
      valid_q   <= valid_d;
      period_q  <= period_d;
      high_q    <= high_d;
      sat_q     <= sat_d;
      dropped_q <= dropped_d;
    end
  end

  assign out_valid_o = valid_q;
  assign period_o    = period_q;
  assign high_cnt_o  = high_q;
  assign sat_o       = sat_q;
  assign dropped_o   = dropped_q;
  assign level_o     = level_q;

endmodule

// File: tb/tb_pwm_edge_meter.sv
// Directed bench for pwm_edge_meter: a 24-bit counter instance plus an 8-bit
// instance sharing the same stimulus for the saturation case.
module tb_pwm_edge_meter;

  localparam int H = 16384;
  localparam int L = -16384;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] v_in;
  logic               out_ready;
  logic               out_valid, sat, dropped, level;
  logic [23:0]        period, high_cnt;
  logic               out_valid8, sat8, dropped8, level8;
  logic [7:0]         period8, high8;

  int vec_cnt = 0;
  int err_cnt = 0;
  int q_per[$], q_hi[$], q_sat[$];
  int q8_per[$], q8_hi[$], q8_sat[$];

  pwm_edge_meter #(.WIDTH(16), .CNT_W(24), .TH_HI(1000), .TH_LO(-1000)) dut (
    .clk_i(clk), .rst_ni(rst_n), .v_in_i(v_in), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .period_o(period), .high_cnt_o(high_cnt),
    .sat_o(sat), .dropped_o(dropped), .level_o(level)
  );

  pwm_edge_meter #(.WIDTH(16), .CNT_W(8), .TH_HI(1000), .TH_LO(-1000)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .v_in_i(v_in), .out_valid_o(out_valid8),
    .out_ready_i(out_ready), .period_o(period8), .high_cnt_o(high8),
    .sat_o(sat8), .dropped_o(dropped8), .level_o(level8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so a negedge sample of valid&&ready marks a handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_per.push_back(int'(period));
      q_hi.push_back(int'(high_cnt));
      q_sat.push_back(int'(sat));
    end
    if (rst_n && out_valid8 && out_ready) begin
      q8_per.push_back(int'(period8));
      q8_hi.push_back(int'(high8));
      q8_sat.push_back(int'(sat8));
    end
  end

  task automatic drive(input int val, input int n);
    for (int i = 0; i < n; i++) begin
      v_in = 16'(val);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v_in = 16'(L);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_per.delete(); q_hi.delete(); q_sat.delete();
    q8_per.delete(); q8_hi.delete(); q8_sat.delete();
    drive(L, 4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    v_in = 16'(H);
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid got %b want 0", out_valid); end
    vec_cnt++; if (period !== 24'd0) begin err_cnt++; $display("FAIL rst_period got %0d want 0", period); end
    vec_cnt++; if (high_cnt !== 24'd0) begin err_cnt++; $display("FAIL rst_high got %0d want 0", high_cnt); end
    vec_cnt++; if (sat !== 1'b0) begin err_cnt++; $display("FAIL rst_sat got %b want 0", sat); end
    vec_cnt++; if (dropped !== 1'b0) begin err_cnt++; $display("FAIL rst_dropped got %b want 0", dropped); end
    vec_cnt++; if (level !== 1'b0) begin err_cnt++; $display("FAIL rst_level got %b want 0", level); end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    drive(H, 50); drive(L, 50);
    vec_cnt++; if (out_valid !== 1'b0 || q_per.size() != 0) begin
      err_cnt++; $display("FAIL basic_early got valid=%b n=%0d want valid=0 n=0", out_valid, q_per.size());
    end
    drive(H, 1);
    vec_cnt++; if (out_valid !== 1'b1 || period !== 24'd100 || high_cnt !== 24'd50) begin
      err_cnt++; $display("FAIL basic_latency got v=%b %0d/%0d want v=1 100/50", out_valid, period, high_cnt);
    end
    drive(H, 49); drive(L, 50);
    for (int p = 0; p < 3; p++) begin drive(H, 50); drive(L, 50); end
    vec_cnt++; if (q_per.size() != 4) begin err_cnt++; $display("FAIL basic_count got %0d want 4", q_per.size()); end
    for (int i = 0; i < q_per.size() && i < 4; i++) begin
      vec_cnt++;
      if (q_per[i] != 100 || q_hi[i] != 50 || q_sat[i] != 0) begin
        err_cnt++; $display("FAIL basic_res[%0d] got %0d/%0d/%0d want 100/50/0", i, q_per[i], q_hi[i], q_sat[i]);
      end
    end
  endtask

  task automatic test_duty25();
    do_reset();
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin drive(H, 25); drive(L, 75); end
    vec_cnt++; if (q_per.size() != 3) begin err_cnt++; $display("FAIL duty_count got %0d want 3", q_per.size()); end
    for (int i = 0; i < q_per.size() && i < 3; i++) begin
      vec_cnt++;
      if (q_per[i] != 100 || q_hi[i] != 25 || q_sat[i] != 0) begin
        err_cnt++; $display("FAIL duty_res[%0d] got %0d/%0d/%0d want 100/25/0", i, q_per[i], q_hi[i], q_sat[i]);
      end
    end
  endtask

  task automatic test_hysteresis();
    int ep[5];
    int eh[5];
    ep = '{100, 100, 100, 21, 79};
    eh = '{50, 50, 50, 20, 29};
    do_reset();
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      drive(H, 20); drive(-500, 5);
      vec_cnt++; if (level !== 1'b1) begin err_cnt++; $display("FAIL hyst_hi[%0d] got %b want 1", p, level); end
      drive(H, 25); drive(L, 20); drive(500, 5);
      vec_cnt++; if (level !== 1'b0) begin err_cnt++; $display("FAIL hyst_lo[%0d] got %b want 0", p, level); end
      drive(L, 25);
    end
    // One-cycle dip below TH_LO: fall at +20, rise at +21, fall at +50, rise at +100.
    drive(H, 20); drive(-2000, 1); drive(H, 29); drive(L, 50); drive(H, 1);
    vec_cnt++; if (out_valid !== 1'b1 || period !== 24'd79 || high_cnt !== 24'd29) begin
      err_cnt++; $display("FAIL hyst_split got v=%b %0d/%0d want v=1 79/29", out_valid, period, high_cnt);
    end
    drive(H, 2);
    vec_cnt++; if (q_per.size() != 5) begin err_cnt++; $display("FAIL hyst_count got %0d want 5", q_per.size()); end
    for (int i = 0; i < q_per.size() && i < 5; i++) begin
      vec_cnt++;
      if (q_per[i] != ep[i] || q_hi[i] != eh[i] || q_sat[i] != 0) begin
        err_cnt++; $display("FAIL hyst_res[%0d] got %0d/%0d/%0d want %0d/%0d/0", i, q_per[i], q_hi[i], q_sat[i], ep[i], eh[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive(H, 50); drive(L, 50);
    drive(H, 30); drive(L, 70);
    drive(H, 40); drive(L, 60);
    vec_cnt++; if (out_valid !== 1'b1 || period !== 24'd100 || high_cnt !== 24'd50 || dropped !== 1'b1) begin
      err_cnt++; $display("FAIL bp_hold1 got v=%b %0d/%0d d=%b want v=1 100/50 d=1", out_valid, period, high_cnt, dropped);
    end
    drive(H, 1);
    vec_cnt++; if (out_valid !== 1'b1 || period !== 24'd100 || high_cnt !== 24'd50) begin
      err_cnt++; $display("FAIL bp_hold2 got v=%b %0d/%0d want v=1 100/50", out_valid, period, high_cnt);
    end
    out_ready = 1'b1;
    drive(H, 1);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_release got %b want 0", out_valid); end
    drive(H, 8); drive(L, 90);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_idle got %b want 0", out_valid); end
    out_ready = 1'b0;
    drive(H, 20); drive(L, 80);
    vec_cnt++; if (out_valid !== 1'b1 || period !== 24'd100 || high_cnt !== 24'd10) begin
      err_cnt++; $display("FAIL bp_next got v=%b %0d/%0d want v=1 100/10", out_valid, period, high_cnt);
    end
    out_ready = 1'b1;
    drive(H, 1);
    vec_cnt++; if (out_valid !== 1'b1 || period !== 24'd100 || high_cnt !== 24'd20 || dropped !== 1'b1) begin
      err_cnt++; $display("FAIL bp_simul got v=%b %0d/%0d d=%b want v=1 100/20 d=1", out_valid, period, high_cnt, dropped);
    end
    vec_cnt++; if (q_per.size() != 2) begin
      err_cnt++; $display("FAIL bp_count got %0d want 2", q_per.size());
    end else begin
      vec_cnt++; if (q_hi[0] != 50 || q_hi[1] != 10) begin
        err_cnt++; $display("FAIL bp_order got %0d,%0d want 50,10", q_hi[0], q_hi[1]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    drive(H, 150); drive(L, 150); drive(H, 50); drive(L, 50); drive(H, 3);
    vec_cnt++; if (q8_per.size() != 2) begin
      err_cnt++; $display("FAIL sat8_count got %0d want 2", q8_per.size());
    end else begin
      vec_cnt++; if (q8_per[0] != 255 || q8_hi[0] != 150 || q8_sat[0] != 1) begin
        err_cnt++; $display("FAIL sat8_clip got %0d/%0d/%0d want 255/150/1", q8_per[0], q8_hi[0], q8_sat[0]);
      end
      vec_cnt++; if (q8_per[1] != 100 || q8_hi[1] != 50 || q8_sat[1] != 0) begin
        err_cnt++; $display("FAIL sat8_clear got %0d/%0d/%0d want 100/50/0", q8_per[1], q8_hi[1], q8_sat[1]);
      end
    end
    vec_cnt++; if (q_per.size() != 2 || q_per[0] != 300 || q_hi[0] != 150 || q_sat[0] != 0) begin
      err_cnt++; $display("FAIL sat24_wide got n=%0d first=%0d want n=2 first=300/150/0", q_per.size(), (q_per.size() > 0) ? q_per[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    drive(H, 50); drive(L, 50);
    drive(H, 50); drive(L, 50);
    drive(H, 20);
    vec_cnt++; if (out_valid !== 1'b1 || dropped !== 1'b1 || level !== 1'b1) begin
      err_cnt++; $display("FAIL rmid_pre got v=%b d=%b l=%b want 1/1/1", out_valid, dropped, level);
    end
    #3 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (out_valid !== 1'b0 || period !== 24'd0 || high_cnt !== 24'd0 || sat !== 1'b0 || dropped !== 1'b0 || level !== 1'b0) begin
      err_cnt++; $display("FAIL rmid_async got v=%b %0d/%0d s=%b d=%b l=%b want all 0", out_valid, period, high_cnt, sat, dropped, level);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    q_per.delete(); q_hi.delete(); q_sat.delete();
    out_ready = 1'b1;
    drive(L, 4);
    drive(H, 50); drive(L, 50);
    vec_cnt++; if (out_valid !== 1'b0 || q_per.size() != 0) begin
      err_cnt++; $display("FAIL rmid_early got v=%b n=%0d want v=0 n=0", out_valid, q_per.size());
    end
    drive(H, 1);
    vec_cnt++; if (out_valid !== 1'b1 || period !== 24'd100 || high_cnt !== 24'd50 || sat !== 1'b0) begin
      err_cnt++; $display("FAIL rmid_first got v=%b %0d/%0d s=%b want v=1 100/50 s=0", out_valid, period, high_cnt, sat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    v_in = '0;
    test_reset();
    test_basic();
    test_duty25();
    test_hysteresis();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
